if_id_decode: RTL and testbench

- IF/ID pipeline register plus main instruction decoder for the pipelined OTTER core.
- Captures the fetched instruction and PC each cycle, subject to stall and flush.
- From the registered instruction, produces register indices, decode controls, the 3-bit immediate-format select and the 25-bit raw immediate field consumed by the downstream immediate extender.
- Sits between the fetch stage and the ID/EX register.

---
 rtl/otter_decode_pkg.sv | 39 +++
 rtl/main_decoder.sv | 126 ++++++++++++
 rtl/if_id_decode.sv | 113 +++++++++++
 tb/tb_if_id_decode.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/otter_decode_pkg.sv
// Shared decode encodings for the OTTER ID stage: opcodes, immediate-format
// selects (also consumed by the immediate extender), result/ALU-op selects
// and the bubble instruction.
package otter_decode_pkg;

  // Base opcodes, InstrD[6:0]
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Immediate-format select
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  // Writeback result select
  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC4 = 2'd2;

  // ALU operation class
  localparam logic [1:0] ALUOP_ADD   = 2'd0;
  localparam logic [1:0] ALUOP_BR    = 2'd1;
  localparam logic [1:0] ALUOP_FUNCT = 2'd2;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR_WORD = 32'h0000_0013;

endpackage

// File: rtl/main_decoder.sv
// Main instruction decoder: opcode + slot-valid to datapath controls.
// Purely combinational. Optional macro: ILLEGAL_INSTR_DET_EN adds illegal
// instruction detection (funct7 input, illegal output).
module main_decoder
  import otter_decode_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic       valid,
`ifdef ILLEGAL_INSTR_DET_EN
  input  logic [6:0] funct7,
  output logic       illegal,
`endif
  output logic [2:0] imm_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic [1:0] result_src,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       branch,
  output logic       jump,
  output logic       jalr
);

`ifdef ILLEGAL_INSTR_DET_EN
  logic known;
`endif

  // Opcode table, then gating of side-effecting controls for bubbles
  always_comb begin
    imm_src    = IMM_NONE;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    result_src = RES_ALU;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    branch     = 1'b0;
    jump       = 1'b0;
    jalr       = 1'b0;
`ifdef ILLEGAL_INSTR_DET_EN
    known      = 1'b1;
    illegal    = 1'b0;
`endif

    case (opcode)
      OPC_LUI: begin
        imm_src   = IMM_U;
        reg_write = 1'b1;
        alu_src   = 1'b1;
      end
      OPC_AUIPC: begin
        imm_src   = IMM_U;
        reg_write = 1'b1;
      end
      OPC_JAL: begin
        imm_src    = IMM_J;
        reg_write  = 1'b1;
        jump       = 1'b1;
        result_src = RES_PC4;
      end
      OPC_JALR: begin
        imm_src    = IMM_I;
        reg_write  = 1'b1;
        jump       = 1'b1;
        jalr       = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_PC4;
      end
      OPC_BRANCH: begin
        imm_src = IMM_B;
        branch  = 1'b1;
        alu_op  = ALUOP_BR;
      end
      OPC_LOAD: begin
        imm_src    = IMM_I;
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = RES_MEM;
      end
      OPC_STORE: begin
        imm_src   = IMM_S;
        mem_write = 1'b1;
        alu_src   = 1'b1;
      end
      OPC_OPIMM: begin
        imm_src   = IMM_I;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OPC_OP: begin
        reg_write = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      OPC_SYSTEM: begin
        imm_src = IMM_I;
      end
      default: begin
`ifdef ILLEGAL_INSTR_DET_EN
        known = 1'b0;
`endif
      end
    endcase

`ifdef ILLEGAL_INSTR_DET_EN
    // Listed opcodes all end in 2'b11, so !known also covers InstrD[1:0]!=2'b11
    illegal = valid && (!known ||
              ((opcode == OPC_OP) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000)));
    if (illegal) begin
      result_src = RES_ALU;
      alu_src    = 1'b0;
      alu_op     = ALUOP_ADD;
    end
    if (!valid || illegal) begin
`else
    if (!valid) begin
`endif
      imm_src   = IMM_NONE;
      reg_write = 1'b0;
      mem_write = 1'b0;
      branch    = 1'b0;
      jump      = 1'b0;
      jalr      = 1'b0;
    end
  end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register plus field slicing and main decode for the OTTER
// core. Priority per edge: RST, FlushD, StallD, load.
// Optional macro: ILLEGAL_INSTR_DET_EN adds IllegalD and sticky IllegalSeen.
module if_id_decode
  import otter_decode_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [31:0]     InstrF,
  input  logic [XLEN-1:0] PCF,
  input  logic [XLEN-1:0] PCPlus4F,
  input  logic            StallD,
  input  logic            FlushD,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD,
  output logic [2:0]      Funct3D,
  output logic            Funct7b5D,
  output logic [24:0]     ImmD,
  output logic [2:0]      ImmSrcD,
  output logic            RegWriteD,
  output logic            MemWriteD,
  output logic [1:0]      ResultSrcD,
  output logic            ALUSrcD,
  output logic [1:0]      ALUOpD,
  output logic            BranchD,
  output logic            JumpD,
`ifdef ILLEGAL_INSTR_DET_EN
  output logic            IllegalD,
  output logic            IllegalSeen,
`endif
  output logic            JalrD
);

  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_plus4_q;
  logic            valid_q;

  // IF/ID register: flush inserts a bubble but still tracks the F-stage PC
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (FlushD) begin
      instr_q    <= NOP_INSTR;
      pc_q       <= PCF;
      pc_plus4_q <= PCPlus4F;
      valid_q    <= 1'b0;
    end else if (!StallD) begin
      instr_q    <= InstrF;
      pc_q       <= PCF;
      pc_plus4_q <= PCPlus4F;
      valid_q    <= 1'b1;
    end
  end

  assign InstrD    = instr_q;
  assign PCD       = pc_q;
  assign PCPlus4D  = pc_plus4_q;
  assign ValidD    = valid_q;

  // Raw fields are never gated; downstream qualifies them with the controls
  assign Rs1D      = instr_q[19:15];
  assign Rs2D      = instr_q[24:20];
  assign RdD       = instr_q[11:7];
  assign Funct3D   = instr_q[14:12];
  assign Funct7b5D = instr_q[30];
  assign ImmD      = instr_q[31:7];

  main_decoder u_main_decoder (
    .opcode     (instr_q[6:0]),
    .valid      (valid_q),
`ifdef ILLEGAL_INSTR_DET_EN
    .funct7     (instr_q[31:25]),
    .illegal    (IllegalD),
`endif
    .imm_src    (ImmSrcD),
    .reg_write  (RegWriteD),
    .mem_write  (MemWriteD),
    .result_src (ResultSrcD),
    .alu_src    (ALUSrcD),
    .alu_op     (ALUOpD),
    .branch     (BranchD),
    .jump       (JumpD),
    .jalr       (JalrD)
  );

`ifdef ILLEGAL_INSTR_DET_EN
  logic illegal_seen_q;

  // Sticky flag; a stalled illegal slot is not counted until it advances
  always_ff @(posedge CLK) begin
    if (RST) begin
      illegal_seen_q <= 1'b0;
    end else if (IllegalD && !StallD) begin
      illegal_seen_q <= 1'b1;
    end
  end

  assign IllegalSeen = illegal_seen_q;
`endif

endmodule

// File: tb/tb_if_id_decode.sv
// Directed bench for if_id_decode. Inputs change and outputs are sampled
// #1 after the rising edge. Illegal-detection checks need ILLEGAL_INSTR_DET_EN.
module tb_if_id_decode;

  localparam int unsigned XLEN = 32;

  logic            clk;
  logic            rst;
  logic [31:0]     instr_f;
  logic [XLEN-1:0] pc_f;
  logic [XLEN-1:0] pc_plus4_f;
  logic            stall_d;
  logic            flush_d;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4_d;
  logic            valid_d;
  logic [4:0]      rs1_d, rs2_d, rd_d;
  logic [2:0]      funct3_d;
  logic            funct7b5_d;
  logic [24:0]     imm_d;
  logic [2:0]      imm_src_d;
  logic            reg_write_d, mem_write_d, alu_src_d, branch_d, jump_d, jalr_d;
  logic [1:0]      result_src_d, alu_op_d;
`ifdef ILLEGAL_INSTR_DET_EN
  logic            illegal_d, illegal_seen;
`endif

  int checks = 0;
  int errors = 0;

  if_id_decode #(.XLEN(XLEN)) dut (
    .CLK        (clk),
    .RST        (rst),
    .InstrF     (instr_f),
    .PCF        (pc_f),
    .PCPlus4F   (pc_plus4_f),
    .StallD     (stall_d),
    .FlushD     (flush_d),
    .InstrD     (instr_d),
    .PCD        (pc_d),
    .PCPlus4D   (pc_plus4_d),
    .ValidD     (valid_d),
    .Rs1D       (rs1_d),
    .Rs2D       (rs2_d),
    .RdD        (rd_d),
    .Funct3D    (funct3_d),
    .Funct7b5D  (funct7b5_d),
    .ImmD       (imm_d),
    .ImmSrcD    (imm_src_d),
    .RegWriteD  (reg_write_d),
    .MemWriteD  (mem_write_d),
    .ResultSrcD (result_src_d),
    .ALUSrcD    (alu_src_d),
    .ALUOpD     (alu_op_d),
    .BranchD    (branch_d),
    .JumpD      (jump_d),
`ifdef ILLEGAL_INSTR_DET_EN
    .IllegalD   (illegal_d),
    .IllegalSeen(illegal_seen),
`endif
    .JalrD      (jalr_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] instr, input logic [31:0] pc);
    instr_f    = instr;
    pc_f       = pc;
    pc_plus4_f = pc + 32'd4;
    step();
  endtask

  initial begin
    rst = 1'b1; stall_d = 1'b0; flush_d = 1'b0;
    instr_f = 32'h0050_0093; pc_f = 32'h40; pc_plus4_f = 32'h44;

    // Reset held two edges
    step(); step();
    check("rst_instr", instr_d, 32'h0000_0013);
    check("rst_valid", {31'd0, valid_d}, 32'd0);
    check("rst_regwr", {31'd0, reg_write_d}, 32'd0);
    check("rst_immsrc", {29'd0, imm_src_d}, 32'd0);
    check("rst_pc", pc_d, 32'd0);
    check("rst_pc4", pc_plus4_d, 32'd0);

    // First load: addi x1, x0, 5
    rst = 1'b0;
    load(32'h0050_0093, 32'h100);
    check("addi_instr", instr_d, 32'h0050_0093);
    check("addi_valid", {31'd0, valid_d}, 32'd1);
    check("addi_immsrc", {29'd0, imm_src_d}, 32'd1);
    check("addi_regwr", {31'd0, reg_write_d}, 32'd1);
    check("addi_rd", {27'd0, rd_d}, 32'd1);
    check("addi_imm", {7'd0, imm_d}, 32'h0000_A001);
    check("addi_alusrc", {31'd0, alu_src_d}, 32'd1);
    check("addi_aluop", {30'd0, alu_op_d}, 32'd2);
    check("addi_pc", pc_d, 32'h100);
    check("addi_pc4", pc_plus4_d, 32'h104);

    // Format sweep
    load(32'h0011_2623, 32'h104);  // sw x1, 12(x2)
    check("sw_immsrc", {29'd0, imm_src_d}, 32'd2);
    check("sw_memwr", {31'd0, mem_write_d}, 32'd1);
    check("sw_regwr", {31'd0, reg_write_d}, 32'd0);
    check("sw_rs1", {27'd0, rs1_d}, 32'd2);
    check("sw_rs2", {27'd0, rs2_d}, 32'd1);
    check("sw_f3", {29'd0, funct3_d}, 32'd2);

    load(32'h0020_8463, 32'h108);  // beq x1, x2, 8
    check("beq_immsrc", {29'd0, imm_src_d}, 32'd3);
    check("beq_branch", {31'd0, branch_d}, 32'd1);
    check("beq_aluop", {30'd0, alu_op_d}, 32'd1);
    check("beq_regwr", {31'd0, reg_write_d}, 32'd0);

    load(32'h1234_50B7, 32'h10C);  // lui x1, 0x12345
    check("lui_immsrc", {29'd0, imm_src_d}, 32'd4);
    check("lui_regwr", {31'd0, reg_write_d}, 32'd1);
    check("lui_alusrc", {31'd0, alu_src_d}, 32'd1);
    check("lui_rd", {27'd0, rd_d}, 32'd1);

    load(32'h0080_00EF, 32'h110);  // jal x1, 8
    check("jal_immsrc", {29'd0, imm_src_d}, 32'd5);
    check("jal_res", {30'd0, result_src_d}, 32'd2);
    check("jal_jump", {31'd0, jump_d}, 32'd1);
    check("jal_jalr", {31'd0, jalr_d}, 32'd0);

    load(32'h0000_80E7, 32'h114);  // jalr x1, 0(x1)
    check("jalr_immsrc", {29'd0, imm_src_d}, 32'd1);
    check("jalr_jalr", {31'd0, jalr_d}, 32'd1);
    check("jalr_jump", {31'd0, jump_d}, 32'd1);
    check("jalr_res", {30'd0, result_src_d}, 32'd2);

    load(32'h0000_A103, 32'h118);  // lw x2, 0(x1)
    check("lw_res", {30'd0, result_src_d}, 32'd1);
    check("lw_regwr", {31'd0, reg_write_d}, 32'd1);

    load(32'h4020_81B3, 32'h11C);  // sub x3, x1, x2
    check("sub_immsrc", {29'd0, imm_src_d}, 32'd0);
    check("sub_f7b5", {31'd0, funct7b5_d}, 32'd1);
    check("sub_aluop", {30'd0, alu_op_d}, 32'd2);
    check("sub_alusrc", {31'd0, alu_src_d}, 32'd0);

    load(32'h0000_000F, 32'h120);  // fence: unlisted opcode
    check("fence_regwr", {31'd0, reg_write_d}, 32'd0);
    check("fence_immsrc", {29'd0, imm_src_d}, 32'd0);

    // Stall: sw captured, then held for three edges while F changes
    load(32'h0011_2623, 32'h200);
    stall_d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      load(32'h0000_0000 + 32'(i) * 32'h1000_0000 + 32'h0020_8463, 32'h300 + 32'(i) * 4);
      check("stall_instr", instr_d, 32'h0011_2623);
      check("stall_pc", pc_d, 32'h200);
      check("stall_memwr", {31'd0, mem_write_d}, 32'd1);
      check("stall_immsrc", {29'd0, imm_src_d}, 32'd2);
    end
    stall_d = 1'b0;
    load(32'h1234_50B7, 32'h300);
    check("unstall_instr", instr_d, 32'h1234_50B7);
    check("unstall_pc", pc_d, 32'h300);

    // Flush beats stall
    flush_d = 1'b1; stall_d = 1'b1;
    load(32'h0080_00EF, 32'h400);
    check("flush_instr", instr_d, 32'h0000_0013);
    check("flush_valid", {31'd0, valid_d}, 32'd0);
    check("flush_regwr", {31'd0, reg_write_d}, 32'd0);
    check("flush_memwr", {31'd0, mem_write_d}, 32'd0);
    check("flush_jump", {31'd0, jump_d}, 32'd0);
    check("flush_pc", pc_d, 32'h400);
    flush_d = 1'b0; stall_d = 1'b0;

    // Reset while stalled
    load(32'h0080_00EF, 32'h500);
    stall_d = 1'b1;
    load(32'h0011_2623, 32'h504);
    check("hold_jal", instr_d, 32'h0080_00EF);
    rst = 1'b1;
    load(32'h0011_2623, 32'h508);
    check("rststall_instr", instr_d, 32'h0000_0013);
    check("rststall_pc", pc_d, 32'd0);
    check("rststall_valid", {31'd0, valid_d}, 32'd0);
    rst = 1'b0; stall_d = 1'b0;
    load(32'h0020_81B3, 32'h600);  // add x3, x1, x2
    check("resume_instr", instr_d, 32'h0020_81B3);
    check("resume_valid", {31'd0, valid_d}, 32'd1);
    check("resume_regwr", {31'd0, reg_write_d}, 32'd1);

`ifdef ILLEGAL_INSTR_DET_EN
    check("ill_seen0", {31'd0, illegal_seen}, 32'd0);
    check("ill_add", {31'd0, illegal_d}, 32'd0);
    load(32'hFFFF_FFFF, 32'h604);
    check("ill_ff", {31'd0, illegal_d}, 32'd1);
    check("ill_ff_regwr", {31'd0, reg_write_d}, 32'd0);
    check("ill_ff_immsrc", {29'd0, imm_src_d}, 32'd0);
    load(32'h0020_81B3, 32'h608);
    check("ill_seen1", {31'd0, illegal_seen}, 32'd1);
    check("ill_clear", {31'd0, illegal_d}, 32'd0);
    load(32'h0220_81B3, 32'h60C);  // mul: funct7 0000001 on OP
    check("ill_mul", {31'd0, illegal_d}, 32'd1);
    check("ill_mul_regwr", {31'd0, reg_write_d}, 32'd0);
    check("ill_mul_aluop", {30'd0, alu_op_d}, 32'd0);
    load(32'h0000_0013, 32'h610);
    check("ill_seen_hold", {31'd0, illegal_seen}, 32'd1);
    rst = 1'b1;
    step();
    check("ill_seen_rst", {31'd0, illegal_seen}, 32'd0);
    rst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
